// File: rtl/useq_host_link_pkg.sv
// Shared types and constants for the useq host link: FSM state encoding,
// arbitration memory encoding and the legal range of the idle gap.
package useq_host_link_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WR   = 3'd1,
      ST_RD   = 3'd2,
      ST_CAP  = 3'd3,
      ST_GAP  = 3'd4
   } state_t;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_t;

   localparam int GAP_MAX = 255;

   // The gap timer is 8 bits wide, so the gap must fit in one byte.
   function automatic logic gap_in_range(input int gap);
      return (gap >= 0) && (gap <= GAP_MAX);
   endfunction

endpackage

// File: rtl/useq_host_link_gap_timer.sv
// Idle-gap down-counter: loaded on entry to the gap, counts down while the
// link waits, and flags the last gap cycle.
module useq_host_link_gap_timer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       count,
   input  logic [7:0] load_val,
   output logic       done
);

   logic [7:0] cnt_q;

   // Load takes priority; counting stops at zero so an idle timer stays put.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 8'd0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (count && (cnt_q != 8'd0)) begin
         cnt_q <= cnt_q - 8'd1;
      end
   end

   // The gap ends in the cycle the counter shows 1, giving exactly load_val idle cycles.
   assign done = (cnt_q == 8'd1);

endmodule

// File: rtl/useq_host_link.sv
// Host-side initiator for the useq message FIFO: pushes host bytes with
// write_fifo pulses, drains the FIFO into a byte stream, one FIFO operation
// at a time with a programmable idle gap after each one.
//
//   state | meaning
//   IDLE  | evaluate write/read eligibility, round-robin on a tie
//   WR    | fifo_write pulse, byte already held in fifo_wdata
//   RD    | fifo_read pulse
//   CAP   | fifo_rdata valid, captured into m_data
//   GAP   | idle cycles so the useq flags settle before the next decision
module useq_host_link
   import useq_host_link_pkg::*;
#(
   parameter int GAP_CYCLES = 1,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       s_data,
   input  logic             s_valid,
   output logic             s_ready,
   output logic [7:0]       m_data,
   output logic             m_valid,
   input  logic             m_ready,
   input  logic             drain_en,
   output logic [7:0]       fifo_wdata,
   output logic             fifo_write,
   output logic             fifo_read,
   input  logic [7:0]       fifo_rdata,
   input  logic             fifo_empty,
   input  logic             fifo_full,
   output logic [CNT_W-1:0] wr_count,
   output logic [CNT_W-1:0] rd_count,
   output logic             busy
);

   if (!gap_in_range(GAP_CYCLES)) begin : g_gap_range
      $error("useq_host_link: GAP_CYCLES must be within 0..255");
   end

   localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES);
   localparam logic       HAS_GAP  = (GAP_CYCLES != 0);

   state_t           state_q, state_d;
   op_t              last_op_q, last_op_d;
   logic [7:0]       wdata_q;
   logic [7:0]       mdata_q;
   logic             mvalid_q;
   logic [CNT_W-1:0] wr_cnt_q, rd_cnt_q;
   logic             wr_ok, rd_ok;
   logic             wr_sel;
   logic             gap_load, gap_count, gap_done;

   assign wr_ok = s_valid & ~fifo_full;
   assign rd_ok = drain_en & ~fifo_empty & ~mvalid_q;

   // State and arbitration memory.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         last_op_q <= OP_RD;
      end else begin
         state_q   <= state_d;
         last_op_q <= last_op_d;
      end
   end

   // Next-state decode, write/read selection and gap timer control.
   always_comb begin
      state_d   = state_q;
      last_op_d = last_op_q;
      wr_sel    = 1'b0;
      gap_load  = 1'b0;
      gap_count = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (wr_ok && (!rd_ok || (last_op_q == OP_RD))) begin
               wr_sel    = 1'b1;
               state_d   = ST_WR;
               last_op_d = OP_WR;
            end else if (rd_ok) begin
               state_d   = ST_RD;
               last_op_d = OP_RD;
            end
         end
         ST_WR, ST_CAP: begin
            if (HAS_GAP) begin
               state_d  = ST_GAP;
               gap_load = 1'b1;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_RD: begin
            state_d = ST_CAP;
         end
         ST_GAP: begin
            gap_count = 1'b1;
            if (gap_done) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   useq_host_link_gap_timer u_gap_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (gap_load),
      .count    (gap_count),
      .load_val (GAP_LOAD),
      .done     (gap_done)
   );

   // Byte registers: write byte latched on the handshake, read byte in CAP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdata_q <= 8'd0;
         mdata_q <= 8'd0;
      end else begin
         if (wr_sel) begin
            wdata_q <= s_data;
         end
         if (state_q == ST_CAP) begin
            mdata_q <= fifo_rdata;
         end
      end
   end

   // m_valid sets on capture and holds until the consumer takes the byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mvalid_q <= 1'b0;
      end else if (state_q == ST_CAP) begin
         mvalid_q <= 1'b1;
      end else if (mvalid_q && m_ready) begin
         mvalid_q <= 1'b0;
      end
   end

   // Statistics counters, wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
      end else begin
         if (state_q == ST_WR) begin
            wr_cnt_q <= wr_cnt_q + 1'b1;
         end
         if (state_q == ST_CAP) begin
            rd_cnt_q <= rd_cnt_q + 1'b1;
         end
      end
   end

   // s_ready is gated by reset so it reads 0 while the block is held in reset.
   assign s_ready    = wr_sel & rst_n;
   assign fifo_write = (state_q == ST_WR);
   assign fifo_read  = (state_q == ST_RD);
   assign fifo_wdata = wdata_q;
   assign m_data     = mdata_q;
   assign m_valid    = mvalid_q;
   assign wr_count   = wr_cnt_q;
   assign rd_count   = rd_cnt_q;
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: doc/useq_host_link.md
# useq_host_link

Host-side initiator for the `useq` message FIFO. It turns a byte stream from host logic into `write_fifo` pulses and drains the `useq` FIFO into a byte stream, one FIFO operation at a time. Every host FIFO operation stalls the sequencer for that cycle, so the block enforces a programmable idle gap between operations. It sits between the host fabric (UART bridge, SPI slave, etc.) and one `useq` instance.

## Interface
Parameters:
- `GAP_CYCLES`, 1: minimum idle cycles after each FIFO operation before the next one may issue; legal range 0–255.
- `CNT_W`, 16: width of the write and read statistics counters.

Ports. Clock and reset are fixed: one clock, and reset is asynchronous and active-low.
- `clk` in 1: the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_data` in 8: byte to push into the useq FIFO.
- `s_valid` in 1: `s_data` is valid.
- `s_ready` out 1: byte accepted this cycle.
- `m_data` out 8: byte drained from the useq FIFO.
- `m_valid` out 1: `m_data` is valid.
- `m_ready` in 1: consumer accepts `m_data`.
- `drain_en` in 1: allows automatic draining of the useq FIFO.
- `fifo_wdata` out 8: connects to useq `fifo_in`.
- `fifo_write` out 1: connects to useq `write_fifo`.
- `fifo_read` out 1: connects to useq `read_fifo`.
- `fifo_rdata` in 8: connects to useq `fifo_out`.
- `fifo_empty` in 1: useq FIFO empty flag.
- `fifo_full` in 1: useq FIFO full flag.
- `wr_count` out CNT_W: bytes written so far; wraps.
- `rd_count` out CNT_W: bytes read so far; wraps.
- `busy` out 1: state is not IDLE.

## Operation
- The FSM has five states: IDLE, WR, RD, CAP and GAP.
- **IDLE.** The block evaluates two eligibility conditions:
  - wr_ok = `s_valid` & !`fifo_full`
  - rd_ok = `drain_en` & !`fifo_empty` & !`m_valid`
- **IDLE selection.**
  - If only one condition is true, that operation is selected.
  - If both are true, arbitration is round-robin on `last_op`: the operation not taken last time wins. `last_op` resets to "read", so the first tie goes to write.
  - If neither is true, the FSM stays in IDLE.
- **Write selected.**
  - `s_ready` = 1 combinationally in that IDLE cycle.
  - `s_data` is registered into `fifo_wdata`; next state is WR.
- **WR.** `fifo_write` = 1 for exactly one cycle. `wr_count` increments. Next state is GAP, or IDLE if `GAP_CYCLES` = 0.
- **Read selected.** Next state is RD.
- **RD.** `fifo_read` = 1 for exactly one cycle.
- **CAP.** `fifo_rdata` is registered into `m_data`, `m_valid` is set, and `rd_count` increments. Next state is GAP or IDLE.
- **GAP.** A down-counter is loaded with `GAP_CYCLES` on entry. The FSM returns to IDLE when the counter reaches 1.
- `fifo_write` and `fifo_read` are decoded from registered state only. They are never high together: the useq treats both high as a no-op.
- The block never reads while `fifo_empty` and never writes while `fifo_full`. This prevents the useq from zeroing `o_port` on an empty read.
- `m_valid` holds with `m_data` stable until `m_ready`. It clears on the cycle `m_valid` & `m_ready` is true.
- `s_ready` is 0 in every state except the IDLE write-select cycle.
- **Reset values:** all outputs 0, including `s_ready`; state IDLE; gap counter 0; `last_op` = read.
- **Reset mid-operation:**
  - A pulse on `fifo_write` or `fifo_read` drops asynchronously.
  - A byte held in CAP or in `m_data` is discarded.
  - No partial operation resumes after reset.
- `drain_en` falling mid-read does not abort RD or CAP.

## Timing
- **Write.** The `s_valid` & `s_ready` handshake happens in cycle T. `fifo_write` is high in T+1. The useq count and flags are updated in T+2. The earliest next IDLE decision is in T+2+`GAP_CYCLES`, so flags are never sampled stale.
- **Read.** The read is selected in T. `fifo_read` is high in T+1. `fifo_rdata` is valid in T+2 and captured at the end of T+2. `m_valid` is high in T+3.
- **Throughput.** One write per 2+`GAP_CYCLES` cycles; one read per 3+`GAP_CYCLES` cycles. The useq stalls for exactly one cycle per operation.
- **Counters.** They update on the edge ending WR or CAP and wrap modulo 2^CNT_W.

## Structure
- State encodings and the `GAP_CYCLES` range check belong in the shared header `useq_host_defs.vh`.
- The gap counter and its 8-bit load logic form one natural sub-module: `useq_gap_timer`, with inputs load and count and output done.

## Test plan
- **Single write:** `GAP_CYCLES`=1, `s_data`=0x5A, `s_valid`=1, empty useq FIFO.
  - `fifo_write` is a one-cycle pulse in T+1 with `fifo_wdata`=0x5A.
  - useq R[15]=1 in T+2; `wr_count`=1.
- **Single read:** useq FIFO preloaded with 0xA5 and `drain_en`=1.
  - `fifo_read` pulses in T+1.
  - `m_data`=0xA5 and `m_valid`=1 in T+3.
  - `m_valid` holds while `m_ready`=0 and no further read issues.
- **Full boundary:** `s_valid` held with 20 bytes and FIFO_DEPTH=16, `drain_en`=0.
  - Exactly 16 writes occur; `s_ready` stays 0 afterward; `wr_count`=16.
- **Round-robin:** `s_valid`=1 and `drain_en`=1 with a non-empty FIFO, `m_ready`=1.
  - Operations alternate W,R,W,R.
  - `fifo_write` and `fifo_read` are never both high on any cycle.
- **Gap enforcement:** `GAP_CYCLES`=4 under continuous writes.
  - FIFO op pulses are spaced exactly 6 cycles apart.
- **Reset in RD:** assert `rst_n`=0 while `fifo_read`=1.
  - `fifo_read` drops immediately; `m_valid`=0.
  - The counters and `busy` read 0 after release.
